// File: rtl/cycle_sequencer_pkg.sv
// Shared definitions for the ARMAria instruction-phase sequencer.
// Contents: state codes (also driven out on the phase port), special
// instruction IDs, ctrl_em class boundaries and two small decode helpers.
package cycle_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_WAIT   = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [6:0] ID_RESET = 7'd100;
  localparam logic [6:0] ID_HALT  = 7'd75;
  localparam logic [6:0] ID_INPUT = 7'd72;

  localparam logic [2:0] EM_NONE      = 3'd0;
  localparam logic [2:0] EM_STORE_MAX = 3'd3;
  localparam logic [2:0] EM_LOAD_MAX  = 3'd6;
  localparam logic [2:0] EM_CLEAR     = 3'd7;

  // Store codes 1..3 are the only ones that write memory.
  function automatic logic em_is_store(input logic [2:0] em);
    return (em != EM_NONE) && (em <= EM_STORE_MAX);
  endfunction

  // Stores and loads (1..6) visit the memory phase; none and clear do not.
  function automatic logic em_is_mem(input logic [2:0] em);
    return (em != EM_NONE) && (em <= EM_LOAD_MAX);
  endfunction

endpackage

// File: rtl/cycle_sequencer_edge_detect_rise.sv
// Rising-edge detector for an already-synchronised level input.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous active-high reset (clears the history register)
//   din    - level input
//   rise   - high while din is 1 and was 0 on the previous clock
module edge_detect_rise (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle instruction-phase sequencer for the ARMAria datapath.
// Walks FETCH -> DECODE -> EXEC -> [MEM] -> WB around the combinational
// control decoder, holds the decoder on the RESET ID after power-on, parks in
// HALT and waits for a user confirm on the input instruction in manual mode.
// Ports:
//   clock, reset    - clock (rising edge), asynchronous active-high reset
//   id              - decoded instruction ID
//   ctrl_em         - decoder memory code (0 none, 1..3 store, 4..6 load, 7 clear)
//   ctrl_rb         - decoder register-bank code (0 = no write)
//   mode            - 1 automatic input, 0 manual (input instruction waits)
//   confirm         - synchronised confirm button level
//   force_reset_id  - select ID_RESET into the decoder
//   ir_load, mem_we, rb_we, pc_en - one-cycle datapath strobes
//   halted, waiting - status flags for HALT and WAIT
//   phase           - current state code
//   retired         - retired-instruction counter (wraps)
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned MEM_WAIT     = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       id,
  input  logic [2:0]       ctrl_em,
  input  logic [2:0]       ctrl_rb,
  input  logic             mode,
  input  logic             confirm,
  output logic             force_reset_id,
  output logic             ir_load,
  output logic             mem_we,
  output logic             rb_we,
  output logic             pc_en,
  output logic             halted,
  output logic             waiting,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int unsigned MemW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
  localparam logic [MemW-1:0] MemLast = MemW'(MEM_WAIT - 1);

  state_e           state_q, state_d;
  logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
  logic [MemW-1:0]  mem_cnt_q, mem_cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             confirm_rise;

  // History register samples confirm in every state, so a button already
  // held when WAIT is entered produces no edge until released and re-pressed.
  edge_detect_rise u_confirm_edge (
    .clock (clock),
    .reset (reset),
    .din   (confirm),
    .rise  (confirm_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      rst_cnt_q <= '0;
      mem_cnt_q <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    mem_cnt_d      = mem_cnt_q;
    retired_d      = retired_q;
    force_reset_id = 1'b0;
    ir_load        = 1'b0;
    mem_we         = 1'b0;
    rb_we          = 1'b0;
    pc_en          = 1'b0;
    halted         = 1'b0;
    waiting        = 1'b0;

    case (state_q)
      S_RST: begin
        force_reset_id = 1'b1;
        if (rst_cnt_q == RstLast) begin
          rst_cnt_d = '0;
          state_d   = S_FETCH;
        end else begin
          rst_cnt_d = rst_cnt_q + RstW'(1);
        end
      end
      S_FETCH: begin
        ir_load = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (id == ID_HALT) begin
          state_d = S_HALT;
        end else if ((id == ID_INPUT) && !mode) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        mem_cnt_d = '0;
        state_d   = em_is_mem(ctrl_em) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // Single write strobe at the start of the memory phase.
        mem_we = (mem_cnt_q == '0) && em_is_store(ctrl_em);
        if (mem_cnt_q == MemLast) begin
          mem_cnt_d = '0;
          state_d   = S_WB;
        end else begin
          mem_cnt_d = mem_cnt_q + MemW'(1);
        end
      end
      S_WB: begin
        rb_we     = (ctrl_rb != 3'd0);
        pc_en     = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_WAIT: begin
        waiting = 1'b1;
        if (confirm_rise) begin
          state_d = S_EXEC;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  assign phase   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer. The counter is narrowed to 8 bits so the
// retired-count wrap is reached in about a thousand cycles.
module tb_cycle_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] id;
  logic [2:0] ctrl_em;
  logic [2:0] ctrl_rb;
  logic       mode;
  logic       confirm;
  logic       force_reset_id, ir_load, mem_we, rb_we, pc_en, halted, waiting;
  logic [2:0] phase;
  logic [7:0] retired;
  logic [9:0] obs;

  int total = 0;
  int bad   = 0;

  cycle_sequencer #(
    .RESET_CYCLES (4),
    .MEM_WAIT     (2),
    .CNT_W        (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .id             (id),
    .ctrl_em        (ctrl_em),
    .ctrl_rb        (ctrl_rb),
    .mode           (mode),
    .confirm        (confirm),
    .force_reset_id (force_reset_id),
    .ir_load        (ir_load),
    .mem_we         (mem_we),
    .rb_we          (rb_we),
    .pc_en          (pc_en),
    .halted         (halted),
    .waiting        (waiting),
    .phase          (phase),
    .retired        (retired)
  );

  always #5 clock = ~clock;

  assign obs = {force_reset_id, ir_load, mem_we, rb_we, pc_en, halted, waiting, phase};

  // Expected output vector for a given phase and strobe set.
  function automatic logic [9:0] ev(input logic [2:0] ph, input logic ir, input logic mw,
                                    input logic rw, input logic pc);
    return {ph == 3'd0, ir, mw, rw, pc, ph == 3'd7, ph == 3'd6, ph};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input logic [9:0] exp);
    check_eq(tag, {22'd0, obs}, {22'd0, exp});
    tick();
  endtask

  task automatic reset_seq();
    for (int i = 0; i < 4; i++) step("rst_hold", ev(3'd0, 0, 0, 0, 0));
  endtask

  initial begin
    reset   = 1'b1;
    id      = 7'd4;
    ctrl_em = 3'd0;
    ctrl_rb = 3'd1;
    mode    = 1'b1;
    confirm = 1'b0;

    #3;
    check_eq("reset_out", {22'd0, obs}, {22'd0, ev(3'd0, 0, 0, 0, 0)});
    check_eq("reset_ret", {24'd0, retired}, 32'd0);
    tick();
    reset = 1'b0;
    reset_seq();

    // Non-memory instruction with register write.
    step("a_fetch", ev(3'd1, 1, 0, 0, 0));
    step("a_dec",   ev(3'd2, 0, 0, 0, 0));
    step("a_exec",  ev(3'd3, 0, 0, 0, 0));
    check_eq("a_ret_pre", {24'd0, retired}, 32'd0);
    step("a_wb",    ev(3'd5, 0, 0, 1, 1));
    check_eq("a_ret", {24'd0, retired}, 32'd1);

    // Store: write strobe on first MEM cycle only.
    id = 7'd40; ctrl_em = 3'd3; ctrl_rb = 3'd0;
    step("b_fetch", ev(3'd1, 1, 0, 0, 0));
    step("b_dec",   ev(3'd2, 0, 0, 0, 0));
    step("b_exec",  ev(3'd3, 0, 0, 0, 0));
    step("b_mem0",  ev(3'd4, 0, 1, 0, 0));
    step("b_mem1",  ev(3'd4, 0, 0, 0, 0));
    step("b_wb",    ev(3'd5, 0, 0, 0, 1));
    check_eq("b_ret", {24'd0, retired}, 32'd2);

    // Load: memory phase without write strobe.
    id = 7'd41; ctrl_em = 3'd5; ctrl_rb = 3'd2;
    step("c_fetch", ev(3'd1, 1, 0, 0, 0));
    step("c_dec",   ev(3'd2, 0, 0, 0, 0));
    step("c_exec",  ev(3'd3, 0, 0, 0, 0));
    step("c_mem0",  ev(3'd4, 0, 0, 0, 0));
    step("c_mem1",  ev(3'd4, 0, 0, 0, 0));
    step("c_wb",    ev(3'd5, 0, 0, 1, 1));
    check_eq("c_ret", {24'd0, retired}, 32'd3);

    // Clear code skips the memory phase.
    id = 7'd7; ctrl_em = 3'd7; ctrl_rb = 3'd0;
    step("d_fetch", ev(3'd1, 1, 0, 0, 0));
    step("d_dec",   ev(3'd2, 0, 0, 0, 0));
    step("d_exec",  ev(3'd3, 0, 0, 0, 0));
    step("d_wb",    ev(3'd5, 0, 0, 0, 1));
    check_eq("d_ret", {24'd0, retired}, 32'd4);

    // Manual input with confirm already held: needs release and re-press.
    id = 7'd72; ctrl_em = 3'd0; ctrl_rb = 3'd0; mode = 1'b0; confirm = 1'b1;
    step("e_fetch", ev(3'd1, 1, 0, 0, 0));
    step("e_dec",   ev(3'd2, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) step("e_wait_held", ev(3'd6, 0, 0, 0, 0));
    confirm = 1'b0;
    step("e_wait_low", ev(3'd6, 0, 0, 0, 0));
    confirm = 1'b1;
    step("e_wait_rise", ev(3'd6, 0, 0, 0, 0));
    step("e_exec",  ev(3'd3, 0, 0, 0, 0));
    step("e_wb",    ev(3'd5, 0, 0, 0, 1));
    check_eq("e_ret", {24'd0, retired}, 32'd5);

    // Automatic mode: input instruction does not wait.
    mode = 1'b1; confirm = 1'b0;
    step("f_fetch", ev(3'd1, 1, 0, 0, 0));
    step("f_dec",   ev(3'd2, 0, 0, 0, 0));
    step("f_exec",  ev(3'd3, 0, 0, 0, 0));
    step("f_wb",    ev(3'd5, 0, 0, 0, 1));
    check_eq("f_ret", {24'd0, retired}, 32'd6);

    // Asynchronous reset in the middle of a store.
    id = 7'd40; ctrl_em = 3'd3;
    step("g_fetch", ev(3'd1, 1, 0, 0, 0));
    step("g_dec",   ev(3'd2, 0, 0, 0, 0));
    step("g_exec",  ev(3'd3, 0, 0, 0, 0));
    check_eq("g_mem", {22'd0, obs}, {22'd0, ev(3'd4, 0, 1, 0, 0)});
    #2 reset = 1'b1;
    #1;
    check_eq("g_rst_out", {22'd0, obs}, {22'd0, ev(3'd0, 0, 0, 0, 0)});
    check_eq("g_rst_ret", {24'd0, retired}, 32'd0);
    #1 reset = 1'b0;
    reset_seq();

    // HALT persists until reset.
    id = 7'd75; ctrl_em = 3'd0;
    step("h_fetch", ev(3'd1, 1, 0, 0, 0));
    step("h_dec",   ev(3'd2, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) step("h_halt", ev(3'd7, 0, 0, 0, 0));
    #2 reset = 1'b1;
    #1;
    check_eq("h_rst_out", {22'd0, obs}, {22'd0, ev(3'd0, 0, 0, 0, 0)});
    #1 reset = 1'b0;
    reset_seq();

    // Counter wrap: 255 instructions of 4 cycles each, then one more WB.
    id = 7'd4; ctrl_em = 3'd0; ctrl_rb = 3'd0;
    check_eq("w_start", {22'd0, obs}, {22'd0, ev(3'd1, 1, 0, 0, 0)});
    repeat (255 * 4) tick();
    check_eq("w_fetch", {22'd0, obs}, {22'd0, ev(3'd1, 1, 0, 0, 0)});
    check_eq("w_ret_max", {24'd0, retired}, 32'd255);
    tick();
    tick();
    tick();
    check_eq("w_wb", {22'd0, obs}, {22'd0, ev(3'd5, 0, 0, 0, 1)});
    tick();
    check_eq("w_ret_wrap", {24'd0, retired}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
